// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM states and
// word geometry used by both the controller and the byte assembler.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte-to-word assembler: each accepted byte lands in the lane
// selected by the running byte index; o_complete flags the final byte's handshake.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_complete
);

  logic [BYTE_IDX_W-1:0]     r_idx;
  logic [31:0]               r_word;
  logic [BYTES_PER_WORD-1:0] w_lane_sel;

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane_sel
      assign w_lane_sel[gi] = (r_idx == BYTE_IDX_W'(gi));
    end
  endgenerate

  // Clear wins over accept so an aborted partial word never leaks into the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (w_lane_sel[k]) r_word[8*k +: 8] <= i_data;
      end
      r_idx <= r_idx + BYTE_IDX_W'(1);
    end
  end

  assign o_word     = r_word;
  assign o_complete = i_accept && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Streams bytes into 32-bit instruction words and writes them to imem from
// BASE_ADDR upward, holding the CPU until a complete load has finished.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

  state_t      r_state, w_state_next;
  logic [7:0]  r_count;
  logic [7:0]  r_word_idx;
  logic        r_done, r_err, r_cpu_hold;

  logic        w_can_start, w_start_ok, w_start_zero, w_start_bad;
  logic        w_abort_busy, w_write_go, w_last_word;
  logic        w_accept, w_clear, w_word_complete;
  logic [31:0] w_word;

  assign w_can_start  = ((r_state == IDLE) || (r_state == DONE)) && start && !abort;
  assign w_start_zero = w_can_start && (word_count == 8'd0);
  assign w_start_bad  = w_can_start && ({1'b0, word_count} > MAX_W9);
  assign w_start_ok   = w_can_start && !w_start_zero && !w_start_bad;
  assign w_abort_busy = abort && ((r_state == RECV) || (r_state == WRITE));
  assign w_write_go   = (r_state == WRITE) && !abort;
  assign w_last_word  = (r_word_idx == r_count - 8'd1);

  assign w_accept = in_valid && in_ready;
  assign w_clear  = w_start_ok || w_abort_busy;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_accept   (w_accept),
    .i_data     (in_data),
    .o_word     (w_word),
    .o_complete (w_word_complete)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (abort)                   w_state_next = IDLE;
        else if (w_start_ok)         w_state_next = RECV;
        else if (start)              w_state_next = DONE;
      end
      RECV: begin
        if (abort)                   w_state_next = IDLE;
        else if (w_word_complete)    w_state_next = WRITE;
      end
      WRITE: begin
        if (abort)                   w_state_next = IDLE;
        else if (w_last_word)        w_state_next = DONE;
        else                         w_state_next = RECV;
      end
      default:                       w_state_next = IDLE;
    endcase
  end

  // Rejected or empty starts leave cpu_hold alone: imem contents are unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_word_idx <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else if (w_abort_busy) begin
      r_done     <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else if (w_start_ok) begin
      r_count    <= word_count;
      r_word_idx <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else if (w_start_zero) begin
      r_done <= 1'b1;
      r_err  <= 1'b0;
    end else if (w_start_bad) begin
      r_done <= 1'b0;
      r_err  <= 1'b1;
    end else if (w_write_go) begin
      r_word_idx <= r_word_idx + 8'd1;
      if (w_last_word) begin
        r_done     <= 1'b1;
        r_cpu_hold <= 1'b0;
      end
    end
  end

  assign in_ready   = (r_state == RECV);
  assign busy       = (r_state == RECV) || (r_state == WRITE);
  assign imem_we    = w_write_go;
  assign imem_addr  = BASE_ADDR + (32'(r_word_idx) * 32'(ADDR_STEP));
  assign imem_wdata = w_word;
  assign done       = r_done;
  assign err        = r_err;
  assign cpu_hold   = r_cpu_hold;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of loads against a queue-based
// reference of expected imem writes, plus abort/restart/reset corner sequences.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int          MAXW = 64;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [7:0]  word_count, in_data;
  logic        in_ready, imem_we, busy, done, err, cpu_hold;
  logic [31:0] imem_addr, imem_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    int   wc;
    bit   gappy;
    bit   fixed;
    logic exp_done;
    logic exp_err;
    logic exp_hold;
  } vec_t;

  vec_t vecs[7];

  instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] q[$], input bit gappy, inout int cycles);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < q.size() && guard < 20 * q.size() + 50) begin
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? q[idx] : 8'($urandom);
      @(negedge clk);
      hs = in_valid && in_ready;
      step();
      cycles++;
      guard++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    if (idx < q.size()) chk("feed_timeout", 32'(idx), 32'(q.size()));
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian, written at BASE + 4*i.
  task automatic check_writes(input string tag, input int n, input logic [7:0] q[$]);
    chk($sformatf("%s_nwrites", tag), 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      logic [31:0] ea, ed;
      ea = BASE + 32'(4 * i);
      ed = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], ed);
    end
  endtask

  task automatic make_bytes(input int wc, input bit fixed, output logic [7:0] q[$]);
    q.delete();
    if (fixed) begin
      q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    end else begin
      for (int i = 0; i < 4 * wc; i++) q.push_back(8'($urandom));
    end
  endtask

  task automatic run_load(input string tag, input vec_t v);
    logic [7:0] q[$];
    int  cycles = 0;
    bit  legal;
    legal = (v.wc >= 1) && (v.wc <= MAXW);
    make_bytes(legal ? v.wc : 0, v.fixed, q);
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    word_count = 8'(v.wc);
    step();
    cycles++;
    start = 1'b0;
    if (legal) begin
      chk({tag, "_busy_recv"}, 32'(busy), 32'd1);
      feed(q, v.gappy, cycles);
      step();
      cycles++;
      if (!v.gappy) chk({tag, "_cycles"}, 32'(cycles - 1), 32'(5 * v.wc));
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(v.exp_done));
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(v.exp_hold));
    check_writes(tag, legal ? v.wc : 0, q);
    chk({tag, "_addr_xfree"}, 32'($isunknown(imem_addr) || $isunknown(imem_wdata)), 32'd0);
    $display("load %s wc=%0d gappy=%0d writes=%0d cycles=%0d done=%0d err=%0d hold=%0d",
             tag, v.wc, v.gappy, wr_addr.size(), cycles, done, err, cpu_hold);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] part[$];
    int cyc;
    vec_t v;

    vecs[0] = '{wc: 2,        gappy: 0, fixed: 1, exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[1] = '{wc: 2,        gappy: 1, fixed: 1, exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[2] = '{wc: 0,        gappy: 0, fixed: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[3] = '{wc: MAXW + 1, gappy: 0, fixed: 0, exp_done: 0, exp_err: 1, exp_hold: 0};
    vecs[4] = '{wc: 1,        gappy: 1, fixed: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[5] = '{wc: 3,        gappy: 1, fixed: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[6] = '{wc: MAXW,     gappy: 0, fixed: 0, exp_done: 1, exp_err: 0, exp_hold: 0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    word_count = 8'd0; in_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_load($sformatf("vec%0d", i), vecs[i]);

    // Abort after two bytes of word 1 of a 3-word load.
    wr_addr.delete(); wr_data.delete();
    make_bytes(3, 1'b0, q);
    part.delete();
    for (int i = 0; i < 6; i++) part.push_back(q[i]);
    start = 1'b1; word_count = 8'd3; step(); start = 1'b0;
    cyc = 0;
    feed(part, 1'b1, cyc);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abrt_busy", 32'(busy), 32'd0);
    chk("abrt_hold", 32'(cpu_hold), 32'd1);
    chk("abrt_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    check_writes("abrt", 1, q);
    $display("seq abort_recv writes=%0d hold=%0d", wr_addr.size(), cpu_hold);
    v = '{wc: 2, gappy: 0, fixed: 1, exp_done: 1, exp_err: 0, exp_hold: 0};
    run_load("after_abort", v);

    // Abort landing on the WRITE cycle suppresses that write.
    wr_addr.delete(); wr_data.delete();
    make_bytes(1, 1'b0, q);
    start = 1'b1; word_count = 8'd1; step(); start = 1'b0;
    feed(q, 1'b0, cyc);
    abort = 1'b1;
    @(negedge clk);
    chk("abrtw_we", 32'(imem_we), 32'd0);
    step();
    abort = 1'b0;
    chk("abrtw_busy", 32'(busy), 32'd0);
    chk("abrtw_nwrites", 32'(wr_addr.size()), 32'd0);
    $display("seq abort_write writes=%0d hold=%0d", wr_addr.size(), cpu_hold);

    // Start pulsed mid-load is ignored; original count of 2 is honoured.
    wr_addr.delete(); wr_data.delete();
    make_bytes(2, 1'b1, q);
    part.delete();
    for (int i = 0; i < 2; i++) part.push_back(q[i]);
    start = 1'b1; word_count = 8'd2; step(); start = 1'b0;
    feed(part, 1'b0, cyc);
    start = 1'b1; word_count = 8'd5; step(); start = 1'b0;
    word_count = 8'hAA;
    part.delete();
    for (int i = 2; i < 8; i++) part.push_back(q[i]);
    feed(part, 1'b1, cyc);
    step();
    chk("restart_busy", 32'(busy), 32'd0);
    chk("restart_done", 32'(done), 32'd1);
    check_writes("restart", 2, q);
    $display("seq start_in_recv writes=%0d done=%0d", wr_addr.size(), done);

    // Asynchronous reset mid-RECV.
    wr_addr.delete(); wr_data.delete();
    make_bytes(2, 1'b0, q);
    part.delete();
    for (int i = 0; i < 3; i++) part.push_back(q[i]);
    start = 1'b1; word_count = 8'd2; step(); start = 1'b0;
    feed(part, 1'b0, cyc);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_addr", imem_addr, BASE);
    chk("arst_wdata", imem_wdata, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_hold", 32'(cpu_hold), 32'd1);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("arst_nwrites", 32'(wr_addr.size()), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);
    $display("seq async_reset writes=%0d busy=%0d", wr_addr.size(), busy);

    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1; word_count = 8'd1; step();
    start = 1'b0; abort = 1'b0;
    chk("abst_busy", 32'(busy), 32'd0);
    chk("abst_ready", 32'(in_ready), 32'd0);
    chk("abst_done", 32'(done), 32'd0);
    $display("seq abort_and_start busy=%0d done=%0d", busy, done);
    v = '{wc: 2, gappy: 1, fixed: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
    run_load("recover", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
